// File: rtl/bram_heap_pq_if.sv
// Command/status bundle for bram_heap_pq.
// slave  : the heap side (takes commands, drives status and root key).
// master : the scheduler side.
//   i_wrt, i_read, i_data        -> insert / pop / replace command and key
//   o_ready, o_full, o_empty     <- handshake and occupancy flags
//   o_count, o_data, o_drop      <- entry count, root key, dropped-command pulse
interface bram_heap_pq_if #(
    parameter int QUEUE_SIZE = 1023,
    parameter int DATA_WIDTH = 16
);
    localparam int CW = $clog2(QUEUE_SIZE + 1);

    logic                  i_wrt;
    logic                  i_read;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_ready;
    logic                  o_full;
    logic                  o_empty;
    logic [CW-1:0]         o_count;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_drop;

    modport slave  (input  i_wrt, i_read, i_data,
                    output o_ready, o_full, o_empty, o_count, o_data, o_drop);
    modport master (output i_wrt, i_read, i_data,
                    input  o_ready, o_full, o_empty, o_count, o_data, o_drop);
endinterface

// File: rtl/bram_heap_pq.sv
// Binary-heap priority queue held in an inferred true dual-port RAM.
// Insert sifts up, pop moves the last entry to the root and sifts down,
// replace overwrites the root and sifts down. MAX_HEAP picks max/min root.
// Ports:
//   CLK, RSTn : clock, asynchronous active-low reset
//   bus       : bram_heap_pq_if.slave (commands in, status/root key out)
module bram_heap_pq #(
    parameter int QUEUE_SIZE = 1023,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_HEAP   = 1
) (
    input  logic             CLK,
    input  logic             RSTn,
    bram_heap_pq_if.slave    bus
);
    localparam int CW = $clog2(QUEUE_SIZE + 1);
    localparam int AW = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_SIZE);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] UP_RD  = 3'd1;
    localparam logic [2:0] UP_WT  = 3'd2;
    localparam logic [2:0] UP_CMP = 3'd3;
    localparam logic [2:0] DN_RD  = 3'd4;
    localparam logic [2:0] DN_WT  = 3'd5;
    localparam logic [2:0] DN_CMP = 3'd6;

    logic [2:0]            state;
    logic [CW-1:0]         count, idx;
    logic [DATA_WIDTH-1:0] cur, root;
    logic                  drop, load_cur;

    // RAM: two ports, registered reads that hold until the next read enable
    logic [DATA_WIDTH-1:0] mem [QUEUE_SIZE];
    logic                  we_a, we_b, re_a, re_b;
    logic [AW-1:0]         addr_a, addr_b;
    logic [DATA_WIDTH-1:0] wd_a, wd_b, rd_a, rd_b;

    always_ff @(posedge CLK) begin
        if (we_a) mem[addr_a] <= wd_a;
        if (we_b) mem[addr_b] <= wd_b;
        if (re_a) rd_a <= mem[addr_a];
        if (re_b) rd_b <= mem[addr_b];
    end

    function automatic logic wins(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        return (MAX_HEAP != 0) ? (a > b) : (a < b);
    endfunction

    logic [CW:0]           lc, rc;
    logic [CW-1:0]         parent, best_idx;
    logic                  lc_ok, rc_ok, right_best;
    logic                  accept, do_ins, do_del;
    logic [DATA_WIDTH-1:0] cur_eff, best_key;

    assign lc         = {idx, 1'b0} + (CW+1)'(1);
    assign rc         = {idx, 1'b0} + (CW+1)'(2);
    assign parent     = (idx - CW'(1)) >> 1;
    assign lc_ok      = lc < {1'b0, count};
    assign rc_ok      = rc < {1'b0, count};
    // Ties go to the left child
    assign right_best = rc_ok && wins(rd_b, rd_a);
    assign best_key   = right_best ? rd_b : rd_a;
    assign best_idx   = right_best ? rc[CW-1:0] : lc[CW-1:0];
    // On a pop the last entry arrives from the RAM during the first DN_RD
    assign cur_eff    = load_cur ? rd_a : cur;

    assign accept = (state == IDLE) && (bus.i_wrt || bus.i_read);
    // Replace on an empty heap degenerates to an insert
    assign do_ins = accept && bus.i_wrt && (!bus.i_read || count == '0);
    assign do_del = accept && bus.i_read && !bus.i_wrt;

    always_comb begin
        we_a   = 1'b0;
        we_b   = 1'b0;
        re_a   = 1'b0;
        re_b   = 1'b0;
        addr_a = '0;
        addr_b = '0;
        wd_a   = cur;
        wd_b   = cur;
        case (state)
            IDLE: if (do_del && count != '0) begin
                re_a   = 1'b1;
                addr_a = AW'(count - CW'(1));
            end
            UP_RD: if (idx == '0) begin
                we_a = 1'b1;
            end else begin
                re_a   = 1'b1;
                addr_a = AW'(parent);
            end
            UP_CMP: begin
                we_a   = 1'b1;
                addr_a = AW'(idx);
                if (wins(cur, rd_a)) begin
                    wd_a = rd_a;
                    // Parent was the root: finish by placing cur there now
                    if (parent == '0) we_b = 1'b1;
                end
            end
            DN_RD: if (count != '0) begin
                if (!lc_ok) begin
                    // Leaf: no children to compare, settle immediately
                    we_a   = 1'b1;
                    addr_a = AW'(idx);
                    wd_a   = cur_eff;
                end else begin
                    re_a   = 1'b1;
                    addr_a = AW'(lc);
                    re_b   = rc_ok;
                    addr_b = AW'(rc);
                end
            end
            DN_CMP: begin
                we_a   = 1'b1;
                addr_a = AW'(idx);
                wd_a   = wins(best_key, cur) ? best_key : cur;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            count    <= '0;
            idx      <= '0;
            cur      <= '0;
            root     <= '0;
            drop     <= 1'b0;
            load_cur <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (state)
                IDLE: begin
                    load_cur <= 1'b0;
                    if (do_ins) begin
                        if (count == FULL_CNT) drop <= 1'b1;
                        else begin
                            count <= count + CW'(1);
                            cur   <= bus.i_data;
                            idx   <= count;
                            state <= UP_RD;
                        end
                    end else if (do_del) begin
                        if (count == '0) drop <= 1'b1;
                        else begin
                            count <= count - CW'(1);
                            idx   <= '0;
                            state <= DN_RD;
                            if (count == CW'(1)) root <= '0;
                            else load_cur <= 1'b1;
                        end
                    end else if (accept) begin
                        cur   <= bus.i_data;
                        idx   <= '0;
                        state <= DN_RD;
                    end
                end
                UP_RD: begin
                    if (idx == '0) begin
                        root  <= cur;
                        state <= IDLE;
                    end else state <= UP_WT;
                end
                UP_WT: state <= UP_CMP;
                UP_CMP: begin
                    if (wins(cur, rd_a)) begin
                        idx <= parent;
                        if (parent == '0) begin
                            root  <= cur;
                            state <= IDLE;
                        end else state <= UP_RD;
                    end else state <= IDLE;
                end
                DN_RD: begin
                    load_cur <= 1'b0;
                    cur      <= cur_eff;
                    if (count == '0) state <= IDLE;
                    else if (!lc_ok) begin
                        if (idx == '0) root <= cur_eff;
                        state <= IDLE;
                    end else state <= DN_WT;
                end
                DN_WT: state <= DN_CMP;
                DN_CMP: begin
                    if (wins(best_key, cur)) begin
                        if (idx == '0) root <= best_key;
                        idx   <= best_idx;
                        state <= DN_RD;
                    end else begin
                        if (idx == '0) root <= cur;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready = (state == IDLE);
    assign bus.o_full  = (count == FULL_CNT);
    assign bus.o_empty = (count == '0);
    assign bus.o_count = count;
    assign bus.o_data  = root;
    assign bus.o_drop  = drop;
endmodule
